clink_base_rx_decoder: RTL

- Receive-side decoder for a Camera Link base-configuration port. Runs downstream of the 7:1 deserializer and its CDC.
- Aligns the 7-bit words using the clock-lane pattern 7'b1100011 and drives a bitslip request until alignment holds.
- Unpacks lanes X0..X3 into ports A/B/C plus LVAL/DVAL/FVAL and emits a pixel stream with start-of-frame and end-of-line markers.
- Maintains frame, line and pixel counters for software status.

---
 rtl/clink_base_rx_decoder.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/clink_base_rx_decoder.sv
// Camera Link base-configuration RX decoder: clock-lane word alignment, lane unpack, AXI-Stream pixels, frame stats.
// Build option: define CLINK_TEST_PATTERN_EN to replace tdata with {8'h00, line[7:0], pixel_index[7:0]}.
module clink_base_rx_decoder #(
  parameter int LOCK_COUNT   = 16,
  parameter int MISS_LIMIT   = 4,
  parameter int BITSLIP_WAIT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  input  logic                 word_valid,
  input  logic [6:0]           clk_word,
  input  logic [6:0]           data_word_0,
  input  logic [6:0]           data_word_1,
  input  logic [6:0]           data_word_2,
  input  logic [6:0]           data_word_3,
  output logic                 bitslip,
  output logic                 locked,
  output logic [23:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tlast,
  output logic                 overflow,
  input  logic                 clear_overflow,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] last_line_pixels,
  output logic [CNT_WIDTH-1:0] last_frame_lines
);

  localparam logic [6:0] CLK_PATTERN = 7'b1100011;
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int XW = $clog2(MISS_LIMIT + 1);
  localparam int WW = $clog2(BITSLIP_WAIT + 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_WAIT, ST_VERIFY, ST_LOCKED} state_t;

  state_t        state, state_nxt;
  logic [MW-1:0] match_cnt, match_cnt_nxt;
  logic [XW-1:0] miss_cnt, miss_cnt_nxt;
  logic [WW-1:0] wait_cnt, wait_cnt_nxt;
  logic          bitslip_nxt;
  logic          lose_lock;
  logic          clk_match;

  assign clk_match = (clk_word == CLK_PATTERN);
  assign locked    = (state == ST_LOCKED);

  always_comb begin
    state_nxt     = state;
    match_cnt_nxt = match_cnt;
    miss_cnt_nxt  = miss_cnt;
    wait_cnt_nxt  = wait_cnt;
    bitslip_nxt   = 1'b0;
    lose_lock     = 1'b0;
    if (word_valid) begin
      unique case (state)
        ST_SEARCH: begin
          if (clk_match) begin
            match_cnt_nxt = '0;
            state_nxt     = ST_VERIFY;
          end else begin
            bitslip_nxt  = 1'b1;
            wait_cnt_nxt = '0;
            state_nxt    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WW'(BITSLIP_WAIT - 1)) state_nxt = ST_SEARCH;
          else wait_cnt_nxt = wait_cnt + 1'b1;
        end
        ST_VERIFY: begin
          if (!clk_match) begin
            state_nxt = ST_SEARCH;
          end else if (match_cnt == MW'(LOCK_COUNT - 1)) begin
            miss_cnt_nxt = '0;
            state_nxt    = ST_LOCKED;
          end else begin
            match_cnt_nxt = match_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (clk_match) begin
            miss_cnt_nxt = '0;
          end else if (miss_cnt == XW'(MISS_LIMIT - 1)) begin
            lose_lock = 1'b1;
            state_nxt = ST_SEARCH;
          end else begin
            miss_cnt_nxt = miss_cnt + 1'b1;
          end
        end
        default: state_nxt = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state     <= ST_SEARCH;
      match_cnt <= '0;
      miss_cnt  <= '0;
      wait_cnt  <= '0;
      bitslip   <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_cnt_nxt;
      miss_cnt  <= miss_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      bitslip   <= bitslip_nxt;
    end
  end

  // Stage p0: lane unpack, framing and the one-word lookahead pending pixel
  logic                 fval, lval, dval;
  logic                 prev_fval, in_frame, sof;
  logic                 pend_vld_p0;
  logic [23:0]          pend_data_p0;
  logic [23:0]          pix_data;
  logic [CNT_WIDTH-1:0] pix_cnt, line_cnt, line_nxt;
  logic                 dec_en, fval_rise, fval_fall, is_pix, rel, rel_last, frame_end;
  logic                 load, drop;

  assign dval = data_word_2[6];
  assign fval = data_word_2[5];
  assign lval = data_word_2[4];

`ifdef CLINK_TEST_PATTERN_EN
  logic unused_lanes;
  assign unused_lanes = ^{data_word_0, data_word_1, data_word_2[3:0], data_word_3};
  assign pix_data = {8'h00, line_cnt[7:0], pix_cnt[7:0]};
`else
  logic [7:0] pix_a, pix_b, pix_c;
  logic       unused_res;
  assign pix_a = {data_word_3[1:0], data_word_0[5:0]};
  assign pix_b = {data_word_3[3:2], data_word_1[4:0], data_word_0[6]};
  assign pix_c = {data_word_3[5:4], data_word_2[3:0], data_word_1[6:5]};
  assign unused_res = data_word_3[6];
  assign pix_data = {pix_c, pix_b, pix_a};
`endif

  // The word that drops lock is not decoded, so nothing is released on it.
  assign dec_en    = word_valid && locked && !lose_lock;
  assign fval_rise = fval && !prev_fval;
  assign fval_fall = !fval && prev_fval;
  assign is_pix    = dec_en && (in_frame || fval_rise) && fval && lval && dval;
  assign rel       = dec_en && pend_vld_p0 && (is_pix || !lval || !fval);
  assign rel_last  = rel && !is_pix;
  assign frame_end = dec_en && fval_fall && in_frame;
  assign line_nxt  = rel_last ? line_cnt + 1'b1 : line_cnt;
  assign load      = rel && (!m_axis_tvalid || m_axis_tready);
  assign drop      = rel && m_axis_tvalid && !m_axis_tready;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      prev_fval        <= 1'b1;
      in_frame         <= 1'b0;
      sof              <= 1'b0;
      pend_vld_p0      <= 1'b0;
      pend_data_p0     <= '0;
      pix_cnt          <= '0;
      line_cnt         <= '0;
      frame_cnt        <= '0;
      last_line_pixels <= '0;
      last_frame_lines <= '0;
    end else if (lose_lock) begin
      // prev_fval parks high so a frame already in flight at relock is ignored
      prev_fval   <= 1'b1;
      in_frame    <= 1'b0;
      sof         <= 1'b0;
      pend_vld_p0 <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
    end else if (dec_en) begin
      prev_fval <= fval;
      if (rel) sof <= 1'b0;
      if (fval_rise) begin
        in_frame <= 1'b1;
        sof      <= 1'b1;
        line_cnt <= '0;
        pix_cnt  <= '0;
      end
      if (is_pix) begin
        pend_vld_p0  <= 1'b1;
        pend_data_p0 <= pix_data;
        pix_cnt      <= pix_cnt + 1'b1;
      end else if (rel) begin
        pend_vld_p0 <= 1'b0;
      end
      if (rel_last) begin
        last_line_pixels <= pix_cnt;
        pix_cnt          <= '0;
        line_cnt         <= line_cnt + 1'b1;
      end
      if (frame_end) begin
        frame_cnt        <= frame_cnt + 1'b1;
        last_frame_lines <= line_nxt;
        line_cnt         <= '0;
        in_frame         <= 1'b0;
      end
    end
  end

  // Stage p1: AXI-Stream output register; a release into a stalled slot is dropped
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= pend_data_p0;
        m_axis_tuser  <= sof;
        m_axis_tlast  <= rel_last;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule
